// File: rtl/hc595_scan_scheduler.sv
// Scans hex digits into 16-bit {segments, select} frames for the 74HC595 serializer. LOAD->valid takes 1 cycle, and each digit dwells DWELL_CYCLES after its handshake.
// A frame is held until frame_ready. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module hc595_scan_scheduler #(
  parameter int NUM_DIGITS     = 8,
  parameter int DWELL_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    s_clk,
  input  logic                    s_reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [15:0]             frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [2:0]              digit_idx,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DWELL} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              digit_idx_q, digit_idx_d;
  logic [15:0]             frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;

  logic [31:0] dig_ext;
  logic [7:0]  dp_ext;
  logic [3:0]  nib;
  logic [6:0]  seg7;
  logic        blank;
  logic [7:0]  seg_raw;
  logic [7:0]  seg_byte;
  logic [7:0]  sel_byte;

  // Digit 0 is decoded straight from the inputs because the snapshot is captured on the same edge.
  always_comb begin
    dig_ext = '0;
    dp_ext  = '0;
    dig_ext[4*NUM_DIGITS-1:0] = (digit_idx_q == 3'd0) ? digits_in : snap_dig_q;
    dp_ext[NUM_DIGITS-1:0]    = (digit_idx_q == 3'd0) ? dp_in : snap_dp_q;
    nib = dig_ext[{digit_idx_q, 2'b00} +: 4];
    case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank = (digit_idx_q != 3'd0) && ((dig_ext >> {digit_idx_q, 2'b00}) == 32'd0);
`else
    blank = 1'b0;
`endif
    seg_raw  = {dp_ext[digit_idx_q], blank ? 7'h00 : seg7};
    seg_byte = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    sel_byte = ~(8'd1 << digit_idx_q);
  end

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    frame_d     = frame_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    snap_dig_d  = snap_dig_q;
    snap_dp_d   = snap_dp_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (digit_idx_q == 3'd0) begin
          snap_dig_d = digits_in;
          snap_dp_d  = dp_in;
        end
        frame_d = {seg_byte, sel_byte};
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          cnt_d   = CW'(DWELL_CYCLES - 1);
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          if (digit_idx_q == LAST_IDX) begin
            digit_idx_d = 3'd0;
            done_d      = 1'b1;
          end else begin
            digit_idx_d = digit_idx_q + 3'd1;
          end
          if (enable) begin
            state_d = LOAD;
          end else begin
            state_d     = IDLE;
            digit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      state_q     <= IDLE;
      digit_idx_q <= 3'd0;
      frame_q     <= {SEG_OFF, 8'hFF};
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      snap_dig_q  <= '0;
      snap_dp_q   <= '0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      frame_q     <= frame_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      snap_dig_q  <= snap_dig_d;
      snap_dp_q   <= snap_dp_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign digit_idx   = digit_idx_q;
  assign scan_done   = done_q;
  assign busy        = busy_q;

endmodule
